// File: rtl/bitlogic_responder.sv
// bitlogic_responder: handshaked WIDTH-bit bitwise logic unit. Requests are
// evaluated on acceptance and queued in a 2-entry in-order response buffer.
// The head entry drives resp_*; a second (tail) slot absorbs one extra
// result while the initiator holds off resp_ready.
//
// Handshake: a transfer happens on a rising edge where valid && ready. A
// producer holds its payload stable while valid=1 and ready=0. req_ready
// depends only on buffer state (and rst_n), never on resp_ready.
module bitlogic_responder #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic [2:0]       resp_op,
    output logic             resp_err,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Head entry (drives the outputs) and tail entry.
    logic             head_valid;
    logic [WIDTH-1:0] head_result;
    logic [2:0]       head_op;
    logic             head_err;
    logic             tail_valid;
    logic [WIDTH-1:0] tail_result;
    logic [2:0]       tail_op;
    logic             tail_err;

    logic             accept;
    logic             pop;
    logic [WIDTH-1:0] new_result;
    logic             new_err;

    // Evaluate the requested bitwise function; opcode 111 yields zero + error.
    always_comb begin
        new_result = '0;
        new_err    = 1'b0;
        case (req_op)
            3'b000:  new_result = req_a & req_b;
            3'b001:  new_result = req_a | req_b;
            3'b010:  new_result = req_a ^ req_b;
            3'b011:  new_result = ~(req_a ^ req_b);
            3'b100:  new_result = ~(req_a & req_b);
            3'b101:  new_result = ~(req_a | req_b);
            3'b110:  new_result = ~req_a;
            default: begin
                new_result = '0;
                new_err    = 1'b1;
            end
        endcase
    end

    // Ready whenever a slot is free; held low while reset is asserted.
    assign req_ready = rst_n && !(head_valid && tail_valid);
    assign accept    = req_valid && req_ready;
    assign pop       = head_valid && resp_ready;

    // Buffer update: the tail slot is only used while the head is occupied,
    // so in-order delivery is simply "tail moves into head on pop".
    // Head data is left untouched when the buffer drains, keeping the last
    // outputs stable while empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_valid  <= 1'b0;
            head_result <= '0;
            head_op     <= '0;
            head_err    <= 1'b0;
            tail_valid  <= 1'b0;
            tail_result <= '0;
            tail_op     <= '0;
            tail_err    <= 1'b0;
        end else begin
            if (pop) begin
                if (tail_valid) begin
                    head_result <= tail_result;
                    head_op     <= tail_op;
                    head_err    <= tail_err;
                    if (accept) begin
                        tail_result <= new_result;
                        tail_op     <= req_op;
                        tail_err    <= new_err;
                    end else begin
                        tail_valid  <= 1'b0;
                    end
                end else if (accept) begin
                    head_result <= new_result;
                    head_op     <= req_op;
                    head_err    <= new_err;
                end else begin
                    head_valid  <= 1'b0;
                end
            end else if (accept) begin
                if (!head_valid) begin
                    head_valid  <= 1'b1;
                    head_result <= new_result;
                    head_op     <= req_op;
                    head_err    <= new_err;
                end else begin
                    tail_valid  <= 1'b1;
                    tail_result <= new_result;
                    tail_op     <= req_op;
                    tail_err    <= new_err;
                end
            end
        end
    end

    // Transaction counter wraps; error counter saturates at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txn_count <= '0;
            err_count <= '0;
        end else if (accept) begin
            txn_count <= txn_count + 1'b1;
            if (new_err && err_count != CNT_MAX) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    assign resp_valid  = head_valid;
    assign resp_result = head_result;
    assign resp_op     = head_op;
    assign resp_err    = head_err;

endmodule
